eeg_aram_bank_rsp: RTL and testbench
====================================

// Module: eeg_aram_bank_rsp
// PURPOSE
// - Bank-side responder of the ARAM address/data protocol: one instance per ARAM bank.
// - Accepts the router's per-bank address stream (VLD/LST/RDY/ADD) and issues single-port SRAM reads.
// - Returns read data in request order on the data stream (VLD/LST/RDY/DAT), with full back-pressure support.
// - Sits between the ARAM router's bank-side outputs and the bank SRAM macro.
// PARAMETERS
// - ARAM_ADD_AW  12  address width (word address into bank)
// - ARAM_DAT_DW   4  data word width
// - RSP_BUF_AW    2  log2 of response buffer depth (DEPTH = 2**RSP_BUF_AW, min 2)
// PORTS
// - clk            in   1            single clock, all logic rising-edge
// - rst            in   1            synchronous reset, active-high
// - AARB_ADD_VLD   in   1            address valid
// - AARB_ADD_LST   in   1            last address of burst
// - AARB_ADD_RDY   out  1            address ready
// - AARB_ADD_ADD   in   ARAM_ADD_AW  read address
// - AARB_DAT_VLD   out  1            data valid
// - AARB_DAT_LST   out  1            data is last of burst (LST of matching address)
// - AARB_DAT_RDY   in   1            data ready
// - AARB_DAT_DAT   out  ARAM_DAT_DW  read data
// - SRAM_REN       out  1            SRAM read enable, active-high
// - SRAM_ADD       out  ARAM_ADD_AW  SRAM address (= AARB_ADD_ADD, combinational)
// - SRAM_DAT       in   ARAM_DAT_DW (+1 with parity)  SRAM read data, valid 1 cycle after REN
// - RSP_BUSY       out  1            burst in progress (FSM in BURST)
// BEHAVIOUR
// - Reset: while rst=1 all outputs 0 (incl. AARB_ADD_RDY); FIFO, in-flight flag, FSM cleared; next cycle RDY=1.
// - Reset mid-operation: in-flight SRAM read and buffered data discarded; no DAT_VLD after reset.
// - add_ena = VLD & RDY; dat_ena = DAT_VLD & DAT_RDY.
// - SRAM_REN = add_ena (combinational); SRAM_ADD = AARB_ADD_ADD.
// - In-flight reg: inflt <= add_ena; inflt_lst <= AARB_ADD_LST when add_ena.
// - Cycle after accept (inflt=1): {inflt_lst, SRAM_DAT} pushed into response FIFO.
// - Latency: address accepted in cycle N -> AARB_DAT_VLD earliest in cycle N+2 (registered FIFO head).
// - Credit: cnt = FIFO occupancy + inflt; AARB_ADD_RDY = (cnt < DEPTH) & ~rst. Pop in same cycle does NOT
//   grant credit (RDY is not combinationally dependent on AARB_DAT_RDY). Overflow impossible by construction.
// - Throughput: 1 word/cycle sustained when DAT_RDY=1 and DEPTH>=4.
// - AARB_DAT_VLD = ~empty; DAT/LST = FIFO head; hold stable while VLD & ~RDY.
// - Simultaneous push & pop: allowed at any occupancy, occupancy unchanged; pop from empty never occurs.
// - Pointers wrap modulo DEPTH; occupancy counter RSP_BUF_AW+1 bits.
// - FSM (2 states): IDLE -add_ena & ~LST-> BURST; IDLE -add_ena & LST-> IDLE;
//   BURST -add_ena & LST-> IDLE; else hold. RSP_BUSY = (state==BURST). LST of data matches LST of address 1:1.
// CONFIGURATION
// - Macro ARAM_RSP_PARITY_EN.
// - Defined: SRAM_DAT is ARAM_DAT_DW+1 bits, MSB = even parity over data bits; extra output
//   RSP_PERR (1 bit) set sticky when a word with bad parity is popped (dat_ena), cleared only by rst.
//   Data still delivered unchanged; parity bit not forwarded on AARB_DAT_DAT.
// - Undefined: SRAM_DAT is ARAM_DAT_DW bits, no RSP_PERR port, no parity logic.
// TESTING
// - Single read: ADD=0x010 LST=1, SRAM returns 0xA -> REN same cycle, DAT_VLD at N+2, DAT=0xA, LST=1, BUSY stays 0.
// - Burst of 8 addrs 0x100..0x107, DAT_RDY=1 -> 8 words in order, 1/cycle, LST only on 8th, BUSY 1 from 1st to 8th accept.
// - Back-pressure: DAT_RDY=0, 6 addresses offered -> exactly 4 accepted (DEPTH=4), ADD_RDY=0, DAT held stable;
//   DAT_RDY=1 -> 4 words drain, remaining 2 accepted, all 6 correct in order.
// - Push/pop at full with DAT_RDY toggling 1/0 every cycle -> no loss, no duplication, occupancy never > 4.
// - rst asserted 1 cycle with 3 words buffered + 1 in flight -> all outputs 0 that cycle, no DAT_VLD afterwards, RDY=1 next cycle.
// - ARAM_RSP_PARITY_EN: SRAM returns {1'b0,4'b0001} (bad parity) -> RSP_PERR rises on its pop, stays 1 until rst.

Source files
------------

// File: rtl/eeg_aram_bank_rsp_if.sv
// ---------------------------------------------------------------------------
// eeg_aram_bank_rsp_if
// Purpose : ARAM per-bank address/data handshake bundle between the ARAM
//           router (master) and the bank-side responder (slave).
// Signals : AARB_ADD_VLD/LST/ADD  router -> bank   address stream
//           AARB_ADD_RDY          bank   -> router address ready
//           AARB_DAT_VLD/LST/DAT  bank   -> router read-data stream
//           AARB_DAT_RDY          router -> bank   data ready
// ---------------------------------------------------------------------------
interface eeg_aram_bank_rsp_if #(
  parameter int ARAM_ADD_AW = 12,
  parameter int ARAM_DAT_DW = 4
);
  logic                   AARB_ADD_VLD;
  logic                   AARB_ADD_LST;
  logic                   AARB_ADD_RDY;
  logic [ARAM_ADD_AW-1:0] AARB_ADD_ADD;
  logic                   AARB_DAT_VLD;
  logic                   AARB_DAT_LST;
  logic                   AARB_DAT_RDY;
  logic [ARAM_DAT_DW-1:0] AARB_DAT_DAT;

  // Router side
  modport master (
    output AARB_ADD_VLD, AARB_ADD_LST, AARB_ADD_ADD, AARB_DAT_RDY,
    input  AARB_ADD_RDY, AARB_DAT_VLD, AARB_DAT_LST, AARB_DAT_DAT
  );

  // Bank responder side
  modport slave (
    input  AARB_ADD_VLD, AARB_ADD_LST, AARB_ADD_ADD, AARB_DAT_RDY,
    output AARB_ADD_RDY, AARB_DAT_VLD, AARB_DAT_LST, AARB_DAT_DAT
  );
endinterface

// File: rtl/eeg_aram_bank_rsp.sv
// ---------------------------------------------------------------------------
// eeg_aram_bank_rsp
// Purpose : Bank-side responder of the ARAM address/data protocol. Accepts the
//           router's address stream, issues single-port SRAM reads and returns
//           the read data in request order with full back-pressure.
// Ports   : clk, rst      single clock, synchronous active-high reset
//           aarb          address/data handshake bundle (slave modport)
//           SRAM_REN      SRAM read enable (= address accepted this cycle)
//           SRAM_ADD      SRAM address (= AARB_ADD_ADD)
//           SRAM_DAT      SRAM read data, valid one cycle after SRAM_REN
//           RSP_BUSY      a burst is in progress
//           RSP_PERR      (ARAM_RSP_PARITY_EN only) sticky parity error
// Config  : define ARAM_RSP_PARITY_EN to add an even-parity bit as MSB of
//           SRAM_DAT and the RSP_PERR output.
// ---------------------------------------------------------------------------
module eeg_aram_bank_rsp #(
  parameter int ARAM_ADD_AW = 12,
  parameter int ARAM_DAT_DW = 4,
  parameter int RSP_BUF_AW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  eeg_aram_bank_rsp_if.slave     aarb,
  output logic                   SRAM_REN,
  output logic [ARAM_ADD_AW-1:0] SRAM_ADD,
`ifdef ARAM_RSP_PARITY_EN
  input  logic [ARAM_DAT_DW:0]   SRAM_DAT,
  output logic                   RSP_PERR,
`else
  input  logic [ARAM_DAT_DW-1:0] SRAM_DAT,
`endif
  output logic                   RSP_BUSY
);

  localparam int DEPTH = 1 << RSP_BUF_AW;
  localparam logic [RSP_BUF_AW:0] DEPTH_W = (RSP_BUF_AW + 1)'(DEPTH);

  // Buffer entry layout: {[parity,] lst, data}
`ifdef ARAM_RSP_PARITY_EN
  localparam int ENT_W = ARAM_DAT_DW + 2;
`else
  localparam int ENT_W = ARAM_DAT_DW + 1;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ENT_W-1:0]      buf_mem [DEPTH];
  logic [RSP_BUF_AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [RSP_BUF_AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [RSP_BUF_AW:0]   occ_reg, occ_next;
  logic                  inflt_reg;
  logic                  inflt_lst_reg;
  state_t                state_reg, state_next;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic [RSP_BUF_AW:0]   credit_cnt;
  logic                  add_rdy;
  logic                  add_ena;
  logic                  buf_empty;
  logic                  dat_vld;
  logic                  dat_ena;
  logic                  push;
  logic [ENT_W-1:0]      push_word;
  logic [ENT_W-1:0]      head_word;
  logic [ARAM_DAT_DW-1:0] head_dat;
  logic                  head_lst;

  // Credit counts the read in flight as well as buffered words, so an
  // accepted address always has a slot waiting when its data returns. The
  // pop of the current cycle is deliberately not credited, keeping RDY free
  // of any combinational path from AARB_DAT_RDY.
  assign credit_cnt = occ_reg + {{RSP_BUF_AW{1'b0}}, inflt_reg};
  assign add_rdy    = (credit_cnt < DEPTH_W) & ~rst;
  assign add_ena    = aarb.AARB_ADD_VLD & add_rdy;

  assign buf_empty  = (occ_reg == '0);
  assign dat_vld    = ~buf_empty & ~rst;
  assign dat_ena    = dat_vld & aarb.AARB_DAT_RDY;

  // SRAM data is valid the cycle after the accept; capture it then.
  assign push       = inflt_reg & ~rst;

`ifdef ARAM_RSP_PARITY_EN
  assign push_word  = {SRAM_DAT[ARAM_DAT_DW], inflt_lst_reg, SRAM_DAT[ARAM_DAT_DW-1:0]};
`else
  assign push_word  = {inflt_lst_reg, SRAM_DAT};
`endif

  assign head_word  = buf_mem[rd_ptr_reg];
  assign head_dat   = head_word[ARAM_DAT_DW-1:0];
  assign head_lst   = head_word[ARAM_DAT_DW];

  // -------------------------------------------------------------------------
  // Outputs (all forced low while in reset)
  // -------------------------------------------------------------------------
  assign aarb.AARB_ADD_RDY = add_rdy;
  assign aarb.AARB_DAT_VLD = dat_vld;
  assign aarb.AARB_DAT_LST = head_lst & ~rst;
  assign aarb.AARB_DAT_DAT = rst ? '0 : head_dat;

  assign SRAM_REN = add_ena;
  assign SRAM_ADD = rst ? '0 : aarb.AARB_ADD_ADD;
  assign RSP_BUSY = (state_reg == ST_BURST) & ~rst;

  // -------------------------------------------------------------------------
  // Response buffer storage (no reset: contents are qualified by occ_reg)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[wr_ptr_reg] <= push_word;
    end
  end

  // -------------------------------------------------------------------------
  // Pointer / occupancy next-state. Push and pop together leave the
  // occupancy unchanged at any fill level.
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    occ_next    = occ_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + RSP_BUF_AW'(1);
    end
    if (dat_ena) begin
      rd_ptr_next = rd_ptr_reg + RSP_BUF_AW'(1);
    end
    if (push && !dat_ena) begin
      occ_next = occ_reg + (RSP_BUF_AW + 1)'(1);
    end else if (!push && dat_ena) begin
      occ_next = occ_reg - (RSP_BUF_AW + 1)'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Burst FSM next-state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (add_ena && !aarb.AARB_ADD_LST) begin
          state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        if (add_ena && aarb.AARB_ADD_LST) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      occ_reg       <= '0;
      inflt_reg     <= 1'b0;
      inflt_lst_reg <= 1'b0;
      state_reg     <= ST_IDLE;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
      inflt_reg  <= add_ena;
      if (add_ena) begin
        inflt_lst_reg <= aarb.AARB_ADD_LST;
      end
      state_reg  <= state_next;
    end
  end

`ifdef ARAM_RSP_PARITY_EN
  // -------------------------------------------------------------------------
  // Parity check on the word being popped. The stored bit must equal the
  // XOR of the data bits (even parity); the word is still delivered as-is.
  // -------------------------------------------------------------------------
  logic [ARAM_DAT_DW:0] par_chain;
  logic                 head_par;
  logic                 head_bad;
  logic                 perr_reg;

  assign par_chain[0] = 1'b0;
  for (genvar gi = 0; gi < ARAM_DAT_DW; gi++) begin : g_par
    assign par_chain[gi+1] = par_chain[gi] ^ head_dat[gi];
  end

  assign head_par = head_word[ARAM_DAT_DW+1];
  assign head_bad = head_par ^ par_chain[ARAM_DAT_DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_reg <= 1'b0;
    end else if (dat_ena && head_bad) begin
      perr_reg <= 1'b1;
    end
  end

  assign RSP_PERR = perr_reg & ~rst;
`endif

endmodule

// File: tb/tb_eeg_aram_bank_rsp.sv
// ---------------------------------------------------------------------------
// tb_eeg_aram_bank_rsp
// Directed bench for eeg_aram_bank_rsp (DEPTH=4). The SRAM model returns
// data = ADD[3:0] ^ ADD[7:4] ^ 4'hB one cycle after SRAM_REN; with
// ARAM_RSP_PARITY_EN it prepends even parity, except address 0x3F0 which
// returns a word with bad parity.
// ---------------------------------------------------------------------------
module tb_eeg_aram_bank_rsp;

  logic clk;
  logic rst;

  eeg_aram_bank_rsp_if #(.ARAM_ADD_AW(12), .ARAM_DAT_DW(4)) bus ();

  logic        sram_ren;
  logic [11:0] sram_add;
  logic        rsp_busy;
`ifdef ARAM_RSP_PARITY_EN
  logic [4:0]  sram_q;
  logic        rsp_perr;
`else
  logic [3:0]  sram_q;
`endif

  logic man_rdy;
  logic tog_rdy;
  logic tog_en;

  int total;
  int bad;
  int cyc;

  assign bus.AARB_DAT_RDY = tog_en ? tog_rdy : man_rdy;

  eeg_aram_bank_rsp #(
    .ARAM_ADD_AW(12),
    .ARAM_DAT_DW(4),
    .RSP_BUF_AW (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .aarb    (bus.slave),
    .SRAM_REN(sram_ren),
    .SRAM_ADD(sram_add),
    .SRAM_DAT(sram_q),
`ifdef ARAM_RSP_PARITY_EN
    .RSP_PERR(rsp_perr),
`endif
    .RSP_BUSY(rsp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    tog_rdy = ~tog_rdy;
  end

  // ---------------- SRAM model ----------------
  function automatic logic [3:0] dfun(input logic [11:0] a);
    return a[3:0] ^ a[7:4] ^ 4'hB;
  endfunction

`ifdef ARAM_RSP_PARITY_EN
  function automatic logic [4:0] sfun(input logic [11:0] a);
    logic [3:0] d;
    d = dfun(a);
    if (a == 12'h3F0) return 5'b0_0001;
    return {^d, d};
  endfunction
`else
  function automatic logic [3:0] sfun(input logic [11:0] a);
    return dfun(a);
  endfunction
`endif

  always @(posedge clk) begin
    if (sram_ren) sram_q <= sfun(sram_add);
  end

  // ---------------- Monitor (negedge) ----------------
  logic [4:0] rx_q[$];
  int         rx_cyc[$];
  int         acc_cnt;
  int         out_cnt;
  int         max_out;
  int         stab_err;
  int         post_rst_vld;
  logic       post_en;
  logic       hold_prev;
  logic [4:0] prev_word;

  always @(negedge clk) begin
    if (rst) begin
      out_cnt   = 0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev &&
          !(bus.AARB_DAT_VLD && {bus.AARB_DAT_LST, bus.AARB_DAT_DAT} == prev_word))
        stab_err++;
      if (bus.AARB_ADD_VLD && bus.AARB_ADD_RDY) begin
        acc_cnt++;
        out_cnt++;
      end
      if (bus.AARB_DAT_VLD && bus.AARB_DAT_RDY) begin
        rx_q.push_back({bus.AARB_DAT_LST, bus.AARB_DAT_DAT});
        rx_cyc.push_back(cyc);
        out_cnt--;
      end
      if (out_cnt > max_out) max_out = out_cnt;
      hold_prev = bus.AARB_DAT_VLD && !bus.AARB_DAT_RDY;
      prev_word = {bus.AARB_DAT_LST, bus.AARB_DAT_DAT};
    end
    if (post_en && bus.AARB_DAT_VLD) post_rst_vld++;
  end

  // ---------------- Helpers ----------------
  logic [4:0] exp_q[$];
  int         rx_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [11:0] a, input logic l);
    int n;
    n = 0;
    bus.AARB_ADD_VLD = 1'b1;
    bus.AARB_ADD_ADD = a;
    bus.AARB_ADD_LST = l;
    #1;
    while (!bus.AARB_ADD_RDY && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("send_rdy_%03h", a), bus.AARB_ADD_RDY, 1);
    @(posedge clk); #1;
    bus.AARB_ADD_VLD = 1'b0;
    bus.AARB_ADD_LST = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((out_cnt != 0 || bus.AARB_DAT_VLD) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", (n < 300), 1);
  endtask

  task automatic cmp_rx(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, "_count"}, rx_q.size() - rx_rd, n);
    for (int i = 0; i < n; i++) begin
      if (rx_rd + i < rx_q.size())
        chk($sformatf("%s_w%0d", tag, i), rx_q[rx_rd + i], exp_q[i]);
      else
        chk($sformatf("%s_w%0d_missing", tag, i), 0, 1);
    end
    rx_rd = rx_q.size();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- Directed sequence ----------------
  initial begin
    int acc0;
    total = 0; bad = 0; cyc = 0;
    acc_cnt = 0; out_cnt = 0; max_out = 0; stab_err = 0;
    post_rst_vld = 0; post_en = 1'b0; hold_prev = 1'b0; prev_word = '0;
    rx_rd = 0;
    tog_rdy = 1'b0; tog_en = 1'b0; man_rdy = 1'b1;
    sram_q = '0;
    rst = 1'b1;
    bus.AARB_ADD_VLD = 1'b1;
    bus.AARB_ADD_LST = 1'b0;
    bus.AARB_ADD_ADD = 12'h010;

    // Reset: everything low even with VLD offered
    @(posedge clk); #1;
    chk("rst_add_rdy", bus.AARB_ADD_RDY, 0);
    chk("rst_dat_vld", bus.AARB_DAT_VLD, 0);
    chk("rst_sram_ren", sram_ren, 0);
    chk("rst_sram_add", sram_add, 0);
    chk("rst_busy", rsp_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.AARB_ADD_VLD = 1'b0;
    #1;
    chk("post_rst_rdy", bus.AARB_ADD_RDY, 1);

    // Single read: 0x010 -> 0xA, LST=1
    @(posedge clk); #1;
    bus.AARB_ADD_VLD = 1'b1; bus.AARB_ADD_ADD = 12'h010; bus.AARB_ADD_LST = 1'b1;
    #1;
    chk("single_ren", sram_ren, 1);
    chk("single_sram_add", sram_add, 12'h010);
    @(posedge clk); #1;
    bus.AARB_ADD_VLD = 1'b0; bus.AARB_ADD_LST = 1'b0;
    #1;
    chk("single_ren_off", sram_ren, 0);
    chk("single_vld_n1", bus.AARB_DAT_VLD, 0);
    chk("single_busy", rsp_busy, 0);
    @(posedge clk); #1;
    chk("single_vld_n2", bus.AARB_DAT_VLD, 1);
    chk("single_dat", bus.AARB_DAT_DAT, 4'hA);
    chk("single_lst", bus.AARB_DAT_LST, 1);
    @(posedge clk); #1;
    chk("single_vld_gone", bus.AARB_DAT_VLD, 0);
    exp_q.push_back(5'h1A);
    cmp_rx("single");

    // Burst of 8, DAT_RDY=1
    chk("burst_busy_pre", rsp_busy, 0);
    for (int i = 0; i < 8; i++) begin
      send(12'h100 + 12'(i), (i == 7));
      chk($sformatf("burst_busy_%0d", i), rsp_busy, (i != 7));
    end
    drain();
    chk("burst_rate", rx_cyc[rx_rd + 7] - rx_cyc[rx_rd], 7);
    exp_q = '{5'h0B, 5'h0A, 5'h09, 5'h08, 5'h0F, 5'h0E, 5'h0D, 5'h1C};
    cmp_rx("burst");

    // Back-pressure: 6 offered with DAT_RDY=0, only 4 accepted
    man_rdy = 1'b0;
    acc0 = acc_cnt;
    max_out = 0;
    for (int i = 0; i < 4; i++) send(12'h200 + 12'(i), 1'b0);
    bus.AARB_ADD_VLD = 1'b1; bus.AARB_ADD_ADD = 12'h204; bus.AARB_ADD_LST = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("bp_rdy_low", bus.AARB_ADD_RDY, 0);
    chk("bp_accepted", acc_cnt - acc0, 4);
    chk("bp_outstanding", out_cnt, 4);
    chk("bp_vld", bus.AARB_DAT_VLD, 1);
    chk("bp_head", {bus.AARB_DAT_LST, bus.AARB_DAT_DAT}, 5'h0B);
    man_rdy = 1'b1;
    send(12'h204, 1'b0);
    send(12'h205, 1'b1);
    drain();
    exp_q = '{5'h0B, 5'h0A, 5'h09, 5'h08, 5'h0F, 5'h1E};
    cmp_rx("bp");

    // Push/pop at full with DAT_RDY toggling every cycle
    tog_en = 1'b1;
    for (int i = 0; i < 10; i++) send(12'h300 + 12'(i), (i == 9));
    drain();
    tog_en = 1'b0;
    chk("tog_max_occ", max_out, 4);
    exp_q = '{5'h0B, 5'h0A, 5'h09, 5'h08, 5'h0F, 5'h0E, 5'h0D, 5'h0C, 5'h03, 5'h12};
    cmp_rx("tog");

    // Reset with 3 buffered + 1 in flight
    man_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(12'h400 + 12'(i), 1'b0);
    chk("mid_pre_vld", bus.AARB_DAT_VLD, 1);
    chk("mid_pre_busy", rsp_busy, 1);
    chk("mid_pre_out", out_cnt, 4);
    rst = 1'b1;
    man_rdy = 1'b1;
    bus.AARB_ADD_VLD = 1'b1; bus.AARB_ADD_ADD = 12'h404;
    #1;
    chk("mid_rst_rdy", bus.AARB_ADD_RDY, 0);
    chk("mid_rst_vld", bus.AARB_DAT_VLD, 0);
    chk("mid_rst_dat", {bus.AARB_DAT_LST, bus.AARB_DAT_DAT}, 0);
    chk("mid_rst_ren", sram_ren, 0);
    chk("mid_rst_sram_add", sram_add, 0);
    chk("mid_rst_busy", rsp_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.AARB_ADD_VLD = 1'b0;
    #1;
    chk("mid_post_rdy", bus.AARB_ADD_RDY, 1);
    chk("mid_post_vld", bus.AARB_DAT_VLD, 0);
    rx_rd = rx_q.size();
    post_en = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    post_en = 1'b0;
    chk("mid_no_vld_after", post_rst_vld, 0);
    chk("mid_no_words_after", rx_q.size() - rx_rd, 0);
    chk("mid_busy_after", rsp_busy, 0);

`ifdef ARAM_RSP_PARITY_EN
    // Parity: good word leaves PERR low, bad word sets it sticky
    chk("par_init", rsp_perr, 0);
    send(12'h3F1, 1'b1);
    drain();
    chk("par_good_perr", rsp_perr, 0);
    exp_q.push_back(5'h15);
    cmp_rx("par_good");
    send(12'h3F0, 1'b1);
    drain();
    chk("par_bad_perr", rsp_perr, 1);
    exp_q.push_back(5'h11);
    cmp_rx("par_bad");
    repeat (3) begin @(posedge clk); #1; end
    chk("par_sticky", rsp_perr, 1);
    rst = 1'b1;
    #1;
    chk("par_rst_low", rsp_perr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("par_cleared", rsp_perr, 0);
`endif

    chk("dat_stable_under_stall", stab_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
